// File: rtl/ysyx_dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e    : responder FSM states
//   CNT_W      : width of the latency down-counter
//   ERR_RDATA  : read data returned for out-of-range accesses
//   NLANES     : byte lanes per 32-bit word
package ysyx_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam int unsigned CNT_W     = 4;
  localparam logic [31:0] ERR_RDATA = 32'h0;
  localparam int unsigned NLANES    = 4;

endpackage

// File: rtl/ysyx_dmem_array.sv
// Word-organised storage with per-byte write enables.
//   clk   : write clock
//   be    : per-lane write enables (lane i = bits [8i+7:8i])
//   idx   : word index, used for both the write and the combinational read
//   wdata : lane-aligned write data
//   rdata : current contents of word idx (combinational)
module ysyx_dmem_array
  import ysyx_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [NLANES-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/ysyx_dmem_responder.sv
// Data-memory responder: target side of the LSU memory interface.
// One outstanding request, fixed access latency, byte-masked writes,
// full-word reads, error flag for addresses outside the array.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready          : request handshake
//   req_wen/addr/wdata/wmask     : request payload (wmask[7:4] unused)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_rdata/rsp_err            : word after any write / out-of-range flag
module ysyx_dmem_responder
  import ysyx_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [NLANES-1:0]   mask_q, mask_d;
  logic                inr_q, inr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         req_off;
  logic [IDX_W-1:0]    req_idx;
  logic                req_inr;
  logic                accept;
  logic                commit;

  logic                sel_wen;
  logic [IDX_W-1:0]    sel_idx;
  logic [31:0]         sel_wdata;
  logic [NLANES-1:0]   sel_mask;
  logic                sel_inr;
  logic [31:0]         arr_rdata;
  logic [31:0]         merged;
  logic [NLANES-1:0]   arr_be;
  logic                unused_bits;

  assign req_off = req_addr - BASE_ADDR;
  assign req_idx = req_off[IDX_W+1:2];
  // 33-bit compare so the upper bound cannot wrap past 32'hFFFF_FFFF.
  assign req_inr = ({1'b0, req_addr} >= BASE_EXT) &&
                   ({1'b0, req_addr} < (BASE_EXT + SPAN));
  assign unused_bits = ^{req_off[31:IDX_W+2], req_off[1:0], req_wmask[7:4]};

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the commit happens on the accept edge itself, before the
  // request latches are loaded, so the live request is used while IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      sel_wen   = req_wen;
      sel_idx   = req_idx;
      sel_wdata = req_wdata;
      sel_mask  = req_wmask[NLANES-1:0];
      sel_inr   = req_inr;
    end else begin
      sel_wen   = wen_q;
      sel_idx   = idx_q;
      sel_wdata = wdata_q;
      sel_mask  = mask_q;
      sel_inr   = inr_q;
    end
  end

  always_comb begin
    merged = arr_rdata;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (sel_wen && sel_mask[i]) merged[8*i +: 8] = sel_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    inr_d   = inr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          mask_d  = req_wmask[NLANES-1:0];
          inr_d   = req_inr;
          if (LATENCY == 1) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      rdata_d = sel_inr ? merged : ERR_RDATA;
      err_d   = !sel_inr;
    end
  end

  // A reset on the commit edge abandons the transaction, so no write.
  assign arr_be = (commit && sel_inr && sel_wen && !rst) ? sel_mask : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      inr_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      inr_q   <= inr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  ysyx_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .be   (arr_be),
    .idx  (sel_idx),
    .wdata(sel_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_ysyx_dmem_responder.sv
// Bench for ysyx_dmem_responder: a LATENCY=2 instance driven by directed and
// randomized transactions with stalls, and a LATENCY=1 instance run
// back-to-back; both checked against a word-array reference model.
module tb_ysyx_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned LAT_A = 2;

  logic clk, rst;

  logic        req_valid_a, req_ready_a, req_wen_a, rsp_valid_a, rsp_ready_a, rsp_err_a;
  logic [31:0] req_addr_a, req_wdata_a, rsp_rdata_a;
  logic [7:0]  req_wmask_a;

  logic        req_valid_b, req_ready_b, req_wen_b, rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] req_addr_b, req_wdata_b, rsp_rdata_b;
  logic [7:0]  req_wmask_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];

  ysyx_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT_A)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wen(req_wen_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a), .req_wmask(req_wmask_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  ysyx_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .LATENCY    (1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wen(req_wen_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_wmask(req_wmask_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  // Reference: byte-addressed window onto a word array; outside it -> error.
  task automatic ref_op(input bit sel_b, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] mask,
                        output logic [31:0] rd, output logic err);
    longint unsigned a, lo, hi;
    int unsigned w;
    logic [31:0] word;
    a  = addr;
    lo = BASE;
    hi = lo + 4 * DEPTH;
    if (a < lo || a >= hi) begin
      rd  = 32'h0;
      err = 1'b1;
      return;
    end
    w    = int'((a - lo) / 4);
    word = sel_b ? mem_b[w] : mem_a[w];
    if (wen) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    if (sel_b) mem_b[w] = word;
    else       mem_a[w] = word;
    rd  = word;
    err = 1'b0;
  endtask

  // First 16 requests initialise words 0..15; afterwards random traffic over
  // that window plus occasional out-of-range addresses.
  task automatic gen_req(input int unsigned k, output logic wen, output logic [31:0] addr,
                         output logic [31:0] wdata, output logic [7:0] mask);
    wdata = $urandom;
    if (k < 16) begin
      wen  = 1'b1;
      addr = BASE + 4 * k;
      mask = 8'h0F;
    end else begin
      wen  = 1'($urandom_range(0, 1));
      mask = 8'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0:       addr = 32'h7FFF_FFFC;
          1:       addr = 32'h7FFF_FFFF;
          2:       addr = BASE + 4 * DEPTH;
          3:       addr = 32'hFFFF_FFFC;
          default: addr = 32'h0000_0000;
        endcase
      end else begin
        addr = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic txn_a(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [7:0] mask, input int unsigned stall, input bit hold,
                       output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    logic exp_err;
    int unsigned guard, lat;
    guard = 0;
    while (!req_ready_a && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("a_ready_wait", 32'(req_ready_a), 32'd1);
    req_wen_a   = wen;
    req_addr_a  = addr;
    req_wdata_a = wdata;
    req_wmask_a = mask;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = hold;
    ref_op(1'b0, wen, addr, wdata, mask, exp_rd, exp_err);
    chk("a_ready_low", 32'(req_ready_a), 32'd0);
    lat = 1;
    while (!rsp_valid_a && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (!rsp_valid_a) chk("a_ready_low_wait", 32'(req_ready_a), 32'd0);
    end
    chk("a_latency", lat, LAT_A);
    got_rd  = rsp_rdata_a;
    got_err = rsp_err_a;
    chk("a_rdata", got_rd, exp_rd);
    chk("a_err", 32'(got_err), 32'(exp_err));
    for (int unsigned s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("a_hold_valid", 32'(rsp_valid_a), 32'd1);
      chk("a_hold_rdata", rsp_rdata_a, got_rd);
      chk("a_hold_err", 32'(rsp_err_a), 32'(got_err));
      chk("a_hold_ready", 32'(req_ready_a), 32'd0);
    end
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
    chk("a_valid_clr", 32'(rsp_valid_a), 32'd0);
    chk("a_ready_back", 32'(req_ready_a), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        g_wen;
  logic [31:0] g_addr, g_wdata;
  logic [7:0]  g_mask;

  initial begin
    rst = 1'b1;
    req_valid_a = 0; req_wen_a = 0; req_addr_a = '0; req_wdata_a = '0; req_wmask_a = '0;
    rsp_ready_a = 0;
    req_valid_b = 0; req_wen_b = 0; req_addr_b = '0; req_wdata_b = '0; req_wmask_b = '0;
    rsp_ready_b = 0;

    @(posedge clk); #1;
    chk("rst_valid", 32'(rsp_valid_a), 32'd0);
    chk("rst_ready", 32'(req_ready_a), 32'd1);
    chk("rst_rdata", rsp_rdata_a, 32'h0);
    chk("rst_err", 32'(rsp_err_a), 32'd0);
    chk("rst_ready_b", 32'(req_ready_b), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full write then read back.
    txn_a(1'b1, 32'h8000_0010, 32'h1122_3344, 8'h0F, 0, 1'b0, rd, er);
    chk("wr_full", rd, 32'h1122_3344);
    txn_a(1'b0, 32'h8000_0010, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("rd_full", rd, 32'h1122_3344);
    chk("rd_full_err", 32'(er), 32'd0);

    // Lane-masked write; upper mask bits must be ignored.
    txn_a(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 8'hF5, 0, 1'b0, rd, er);
    chk("wr_mask", rd, 32'h11BB_33DD);
    txn_a(1'b0, 32'h8000_0012, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("rd_mask", rd, 32'h11BB_33DD);

    // Zero-mask write leaves the word alone but still responds.
    txn_a(1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 8'h00, 0, 1'b0, rd, er);
    chk("wr_nomask", rd, 32'h11BB_33DD);

    // Range boundaries.
    txn_a(1'b1, BASE, 32'hCAFE_F00D, 8'h0F, 0, 1'b0, rd, er);
    txn_a(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("below_rdata", rd, 32'h0);
    chk("below_err", 32'(er), 32'd1);
    txn_a(1'b1, BASE + 4 * DEPTH, 32'h5555_5555, 8'h0F, 0, 1'b0, rd, er);
    chk("above_rdata", rd, 32'h0);
    chk("above_err", 32'(er), 32'd1);
    txn_a(1'b0, BASE + 4 * DEPTH - 4, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("top_word_err", 32'(er), 32'd0);
    txn_a(1'b0, BASE, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("word0", rd, 32'hCAFE_F00D);
    chk("word0_err", 32'(er), 32'd0);

    // Response stall with the next request held valid throughout.
    txn_a(1'b0, 32'h8000_0010, 32'h0, 8'h00, 5, 1'b1, rd, er);
    chk("stall_rdata", rd, 32'h11BB_33DD);
    txn_a(1'b0, 32'h8000_0010, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("after_stall", rd, 32'h11BB_33DD);

    // Reset while a write is waiting.
    txn_a(1'b1, 32'h8000_0020, 32'h0, 8'h0F, 0, 1'b0, rd, er);
    req_wen_a = 1'b1; req_addr_a = 32'h8000_0020; req_wdata_a = 32'hDEAD_BEEF;
    req_wmask_a = 8'h0F; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    chk("wait_ready_low", 32'(req_ready_a), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstwait_valid", 32'(rsp_valid_a), 32'd0);
    chk("rstwait_ready", 32'(req_ready_a), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstwait_idle", 32'(rsp_valid_a), 32'd0);
    end
    txn_a(1'b0, 32'h8000_0020, 32'h0, 8'h00, 0, 1'b0, rd, er);
    chk("rstwait_nowrite", rd, 32'h0);

    // Randomized traffic with random response stalls.
    for (int unsigned k = 0; k < 40; k++) begin
      gen_req(k, g_wen, g_addr, g_wdata, g_mask);
      txn_a(g_wen, g_addr, g_wdata, g_mask, $urandom_range(0, 3), 1'b0, rd, er);
    end

    // LATENCY=1 instance, request and response channels always enabled.
    begin
      int unsigned n_issued, n_done, cycles;
      logic prev_ready, acc;
      logic [31:0] exp_rd;
      logic exp_err;
      n_issued = 0; n_done = 0; cycles = 0;
      rsp_ready_b = 1'b1;
      gen_req(n_issued, req_wen_b, req_addr_b, req_wdata_b, req_wmask_b);
      n_issued++;
      req_valid_b = 1'b1;
      prev_ready  = req_ready_b;
      exp_rd = '0; exp_err = 1'b0;
      while (n_done < 200 && cycles < 2000) begin
        @(posedge clk); #1;
        cycles++;
        acc = prev_ready && req_valid_b;
        if (acc) ref_op(1'b1, req_wen_b, req_addr_b, req_wdata_b, req_wmask_b, exp_rd, exp_err);
        chk("b_valid", 32'(rsp_valid_b), 32'(acc));
        chk("b_ready", 32'(req_ready_b), 32'(!acc));
        if (rsp_valid_b) begin
          chk("b_rdata", rsp_rdata_b, exp_rd);
          chk("b_err", 32'(rsp_err_b), 32'(exp_err));
          n_done++;
        end
        prev_ready = req_ready_b;
        if (req_ready_b) begin
          gen_req(n_issued, req_wen_b, req_addr_b, req_wdata_b, req_wmask_b);
          n_issued++;
        end
      end
      req_valid_b = 1'b0;
      chk("b_done", n_done, 32'd200);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_dmem_responder.md
Name: ysyx_dmem_responder

Overview:
Data-memory responder for the core's load/store path: the target end of the memory interface the execute/LSU side drives.
- Accepts one request at a time over a valid/ready request channel.
- Models a configurable access latency.
- Performs byte-lane-masked word writes and full-word reads on an internal word array.
- Returns read data and error status over a valid/ready response channel.
- Replaces direct DPI memory calls in synthesizable builds.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two)
BASE_ADDR, 32'h8000_0000, byte address of word 0
LATENCY, 2, cycles from request accept to rsp_valid (legal range 1..15)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_wen  input  1  1 = write, 0 = read
req_addr  input  32  byte address; bits [1:0] ignored for word selection
req_wdata  input  32  write data, lane-aligned (byte i in bits [8i+7:8i])
req_wmask  input  8  byte-lane enables; bits [3:0] used, bits [7:4] ignored
rsp_valid  output  1  response present
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  32  word at the addressed location after any write
rsp_err  output  1  1 = address outside the array

Behaviour:
Reset:
- State goes to IDLE.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 in the cycle after rst is sampled high.
- Array contents are not reset.

Ready:
- req_ready = (state==IDLE), driven combinationally from registered state.
- Accept occurs on cycle T when req_valid && req_ready.
- On accept, latch wen, word index, wdata, wmask[3:0], and range check.

Word index and range check:
- Word index = (req_addr - BASE_ADDR) >> 2.
- In range iff BASE_ADDR <= req_addr < BASE_ADDR + 4*DEPTH_WORDS, using 33-bit comparison; no wrap past 32'hFFFF_FFFF.

FSM states: IDLE, WAIT, RESP.
- IDLE -> RESP on accept if LATENCY==1.
- IDLE -> WAIT on accept otherwise; 4-bit counter loaded with LATENCY-2.
- WAIT: decrement counter; when counter==0, go to RESP next edge.

Commit (the edge entering RESP):
- In range and wen: each lane i with mask bit set is updated; other lanes are unchanged.
- rsp_rdata <= resulting word (read-after-write within the same transaction sees the new bytes).
- wen with mask 0: no array change; response is still produced.
- Out of range: no array access, rsp_rdata <= 0, rsp_err <= 1.

Timing:
- rsp_valid rises exactly LATENCY cycles after the accept edge.

RESP:
- rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
- On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid.
- req_ready returns the following cycle; there is no same-cycle response/request overlap.
- Peak throughput is one transaction per LATENCY+1 cycles.

Other rules:
- req_* inputs are ignored when req_ready=0.
- req_valid held across a stall is not double-accepted.
- rsp_ready while rsp_valid=0 has no effect.
- rst in WAIT: transaction is abandoned, no write occurs, return to IDLE.
- rst in RESP: the already-committed write stays in the array, the response is dropped, return to IDLE.

Decomposition:
Package ysyx_dmem_pkg:
- state enum (IDLE/WAIT/RESP)
- CNT_W=4
- ERR_RDATA=32'h0
- lane-count constant NLANES=4

Sub-module ysyx_dmem_array:
- DEPTH_WORDS x 32 storage
- per-byte write enables
- combinational read of the indexed word

Top-level block holds the FSM, latency counter, request latches, range check and response registers.

Test Plan:
- Reset, then write addr 32'h8000_0010 wdata 32'h1122_3344 mask 4'hF, then read same addr (LATENCY=2) -> req_ready low from accept; rsp_valid exactly 2 cycles after each accept; read rsp_rdata=32'h1122_3344, rsp_err=0.
- Write 32'hAABB_CCDD mask 4'b0101 over that word -> rsp_rdata=32'h11BB_33DD; a following read returns the same.
- Read addr 32'h7FFF_FFFC, then addr BASE_ADDR+4*DEPTH_WORDS -> both rsp_err=1 and rsp_rdata=0; a subsequent read of word 0 is unaffected.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata, rsp_err stable; req_ready=0 throughout; with req_valid held high, the next request is accepted only the cycle after the response handshake.
- Assert rst during WAIT of a write with mask 4'hF to 32'h8000_0020 holding 32'h0 -> rsp_valid stays 0; after reset, a read of 32'h8000_0020 returns 32'h0.
- LATENCY=1 build, back-to-back requests with rsp_ready tied high -> rsp_valid 1 cycle after each accept; accept every 2 cycles; results match a reference array model over 200 random masked writes and reads.
